mul_share_arbiter: RTL
======================

// Module: mul_share_arbiter
// PURPOSE
//  - Shares one combinational multiplier_4x4 between two requesters in the 4-bit AU.
//  - Round-robin arbitration with one operation in flight and registered operands.
//  - The product is registered and returned with a valid/ready handshake to the winning requester.
//  - Lets two AU clients use one array multiplier instead of instantiating two.
// PARAMETERS
//  - CALC_CYCLES  1  cycles operands are held stable before P is sampled; legal 1..15.
//  - PRIO_INIT    0  requester favoured by the RR pointer after reset; legal 0 or 1.
// PORTS
//  - clk        in   1  single clock, rising edge.
//  - rst        in   1  asynchronous, active-high reset.
//  - req_valid  in   2  bit n: requester n presents operands.
//  - req_ready  out  2  bit n: requester n operands accepted this cycle.
//  - req_a0     in   4  requester 0 operand A.
//  - req_b0     in   4  requester 0 operand B.
//  - req_a1     in   4  requester 1 operand A.
//  - req_b1     in   4  requester 1 operand B.
//  - rsp_valid  out  2  bit n: result for requester n available; one-hot or zero.
//  - rsp_ready  in   2  bit n: requester n takes the result.
//  - rsp_p      out  8  unsigned product; meaningful only while rsp_valid != 0.
//  - busy       out  1  high in CALC or RESP.
// BEHAVIOUR
//  - Reset values: req_ready=0, rsp_valid=0, rsp_p=0, busy=0, state=IDLE, rr_ptr=PRIO_INIT, cnt=0.
//  - FSM states: IDLE, CALC, RESP.
//  - IDLE, grant selection:
//    - Only one requester valid: that requester wins.
//    - Both valid: rr_ptr wins.
//    - req_ready[win] = req_valid[win], combinational; req_ready is 0 in every other state.
//  - IDLE, on handshake:
//    - Latch A/B of the winner into op_a/op_b and latch owner.
//    - Load cnt=CALC_CYCLES-1 and go to CALC.
//  - CALC:
//    - op_a/op_b drive the multiplier and are held constant.
//    - cnt==0: register P into rsp_p and go to RESP. Otherwise decrement cnt.
//  - RESP:
//    - rsp_valid[owner]=1, and rsp_p is held stable until rsp_ready[owner]=1.
//    - On that handshake: rsp_valid=0, rr_ptr=~owner, go to IDLE.
//    - rsp_ready on the non-owner bit is ignored.
//  - Latency: accept at edge T gives rsp_valid high from T+CALC_CYCLES; earliest re-accept is the cycle after the response handshake.
//  - Throughput: at most 1 op per CALC_CYCLES+1 cycles.
//  - Arithmetic: P = op_a*op_b, unsigned 8-bit, no overflow possible (max 225).
//  - Fairness: after a served op, rr_ptr points to the other requester. Continuous requests from both sides alternate 0,1,0,1...
//  - A requester dropping req_valid while not granted is legal; nothing is latched.
//  - rst asserted mid-CALC/RESP: the operation is discarded and no rsp_valid is produced. All state and outputs return to their reset values immediately.
// CONFIGURATION
//  - MUL_SHARE_STATS_EN defined: adds output ports gnt_cnt0[7:0] and gnt_cnt1[7:0].
//    - Each counts accepted ops for its requester.
//    - Saturates at 255; reset to 0.
//  - Without the macro: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Shared package au_pkg holds:
//    - FSM state encoding: ST_IDLE=2'd0, ST_CALC=2'd1, ST_RESP=2'd2.
//    - Width constants: AU_W=4, AU_PW=8.
//  - Sub-module: one multiplier_4x4 instance driven only by op_a/op_b.
//  - No other sub-module.
// TESTING
//  - Single op, requester 0, 3x5, rsp_ready=1, CALC_CYCLES=1:
//    - rsp_valid=2'b01, rsp_p=15.
//    - rsp_valid rises 1 cycle after accept.
//  - Both request, rsp_ready held 1 throughout:
//    - Requester 0 sends 15x15; requester 1 sends 7x9.
//    - PRIO_INIT=0: grants go 0 then 1, with results 225 then 63.
//    - Both held high over 4 ops: grant order is 0,1,0,1.
//  - Backpressure, owner requester 0, ready sequencing:
//    - Hold rsp_ready[0]=0 for 5 cycles: rsp_valid[0] stays 1 and rsp_p stays 225.
//    - req_ready=0 throughout, even with req_valid=2'b10.
//  - Non-owner ready ignored: rsp_ready=2'b10 while owner is requester 0 -> no handshake, state stays RESP.
//  - CALC_CYCLES=4, 0x9: rsp_p=0 and rsp_valid asserts 4 cycles after accept.
//  - Reset mid-CALC:
//    - rsp_valid never pulses and busy=0 immediately.
//    - Next op after reset is granted to PRIO_INIT.
//  - With MUL_SHARE_STATS_EN defined:
//    - 300 ops on requester 1 -> gnt_cnt1=255, gnt_cnt0=0.

Source files
------------

// File: rtl/au_pkg.sv
// Shared 4-bit AU definitions: FSM state encoding and datapath widths.
package au_pkg;

    localparam int AU_W  = 4;
    localparam int AU_PW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } au_state_t;

endpackage

// File: rtl/multiplier_4x4.sv
// Unsigned 4x4 array multiplier, purely combinational, product is 8 bits wide.
module multiplier_4x4
    import au_pkg::*;
(
    input  logic [AU_W-1:0]  a,
    input  logic [AU_W-1:0]  b,
    output logic [AU_PW-1:0] p
);

    // Sum of shifted partial products, one row per bit of b.
    always_comb begin
        p = '0;
        for (int unsigned i = 0; i < AU_W; i++) begin
            if (b[i]) begin
                p = p + (AU_PW'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one multiplier_4x4 between two AU requesters.
// One operation in flight; operands and product are registered and the product
// is returned to the owner through a valid/ready handshake.
// Optional MUL_SHARE_STATS_EN adds saturating per-requester grant counters.
module mul_share_arbiter
    import au_pkg::*;
#(
    parameter int unsigned CALC_CYCLES = 1,
    parameter bit          PRIO_INIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [AU_W-1:0]  req_a0,
    input  logic [AU_W-1:0]  req_b0,
    input  logic [AU_W-1:0]  req_a1,
    input  logic [AU_W-1:0]  req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [AU_PW-1:0] rsp_p,
`ifdef MUL_SHARE_STATS_EN
    output logic [7:0]       gnt_cnt0,
    output logic [7:0]       gnt_cnt1,
`endif
    output logic             busy
);

    localparam logic [3:0] CNT_LOAD = 4'(CALC_CYCLES - 1);

    au_state_t        state;
    au_state_t        state_nxt;
    logic             rr_ptr;
    logic             owner;
    logic             win;
    logic             accept;
    logic             rsp_done;
    logic [3:0]       cnt;
    logic [AU_W-1:0]  op_a;
    logic [AU_W-1:0]  op_b;
    logic [AU_PW-1:0] mul_p;

    multiplier_4x4 u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

    // Grant selection: a lone requester wins, otherwise the RR pointer decides.
    always_comb begin
        win = rr_ptr;
        if (req_valid == 2'b01) begin
            win = 1'b0;
        end else if (req_valid == 2'b10) begin
            win = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready[win] = req_valid[win];
                if (req_valid[win]) begin
                    accept    = 1'b1;
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    rsp_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Operand capture, calc countdown, product register and RR pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            owner  <= 1'b0;
            cnt    <= '0;
            rsp_p  <= '0;
            rr_ptr <= PRIO_INIT;
        end else begin
            if (accept) begin
                op_a  <= win ? req_a1 : req_a0;
                op_b  <= win ? req_b1 : req_b0;
                owner <= win;
                cnt   <= CNT_LOAD;
            end
            if (state == ST_CALC) begin
                if (cnt == '0) begin
                    rsp_p <= mul_p;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
            if (rsp_done) begin
                rr_ptr <= ~owner;
            end
        end
    end

`ifdef MUL_SHARE_STATS_EN
    // Saturating count of accepted operations per requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (accept) begin
            if (!win && gnt_cnt0 != 8'hFF) begin
                gnt_cnt0 <= gnt_cnt0 + 8'd1;
            end
            if (win && gnt_cnt1 != 8'hFF) begin
                gnt_cnt1 <= gnt_cnt1 + 8'd1;
            end
        end
    end
`endif

endmodule
